// File: rtl/decode32_wb_pkg.sv
// Shared definitions for the decode/write-back slice: opcodes, register
// indices, write-back FSM encoding and the immediate-extension helper.
package cpu_defs;

  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    DONE      = 2'd2
  } wb_state_t;

  // Logical immediates (and sltiu) take a zero-extended 16-bit operand.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_SLTIU);
  endfunction

endpackage

// File: rtl/decode32_wb_if.sv
// Load request/acknowledge channel between the write-back block and data memory.
// Handshake: ld_req stays high from the issuing edge until the edge on which
// ld_ack is seen (or the wait times out); ld_addr is valid while ld_req=1;
// ld_data is sampled only in a cycle where ld_ack=1 and ld_req=1.
interface decode32_wb_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic        ld_ack;
  logic [31:0] ld_data;

  modport master (output ld_req, ld_addr, input ld_ack, ld_data);
  modport slave  (input ld_req, ld_addr, output ld_ack, ld_data);
endinterface

// File: rtl/decode32_wb_regfile32.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port. $0 reads as zero and ignores writes; $sp resets to SP_INIT.
module regfile32
  import cpu_defs::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  // Synchronous reset of the whole array, then single-port writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == int'(REG_SP)) ? SP_INIT : 32'h0;
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Unbypassed reads; $0 forced to zero.
  always_comb begin
    rdata1_o = (raddr1_i == REG_ZERO) ? 32'h0 : regs_q[raddr1_i];
    rdata2_o = (raddr2_i == REG_ZERO) ? 32'h0 : regs_q[raddr2_i];
  end

endmodule

// File: rtl/decode32_wb.sv
// Decode/write-back: operand reads, immediate extension, write-back mux and
// the multi-cycle load FSM that stalls fetch until memory answers.
module decode32_wb
  import cpu_defs::*;
#(
  parameter int          LD_TIMEOUT = 16,
  parameter logic [31:0] SP_INIT    = 32'h0000_7FFC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        Instruction,
  input  logic [31:0]        PC_plus_4,
  input  logic [31:0]        ALU_Result,
  input  logic               RegWrite,
  input  logic               RegDst,
  input  logic               MemtoReg,
  input  logic               Jal,
  decode32_wb_if.master      mem,
  output logic [31:0]        Read_data_1,
  output logic [31:0]        Read_data_2,
  output logic [31:0]        Sign_extend,
  output logic               stall,
  output logic               ld_err,
  output wb_state_t          dbg_state
);

  localparam int CNT_W = $clog2(LD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LD_TIMEOUT - 1);

  wb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       dest_q, dest_d;
  logic             ld_req_q, ld_req_d;
  logic [31:0]      ld_addr_q, ld_addr_d;
  logic             ld_err_q, ld_err_d;

  logic [4:0]  dest_now;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  // Destination select and immediate extension are pure decode.
  always_comb begin
    if (Jal)         dest_now = REG_RA;
    else if (RegDst) dest_now = Instruction[15:11];
    else             dest_now = Instruction[20:16];
    if (is_zero_ext(Instruction[31:26])) Sign_extend = {16'h0, Instruction[15:0]};
    else                                 Sign_extend = {{16{Instruction[15]}}, Instruction[15:0]};
  end

  // Load FSM next state, write-back port and stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    ld_req_d  = ld_req_q;
    ld_addr_d = ld_addr_q;
    ld_err_d  = ld_err_q;
    we        = 1'b0;
    waddr     = dest_now;
    wdata     = Jal ? PC_plus_4 : ALU_Result;
    stall     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RegWrite && !MemtoReg) begin
          we = 1'b1;
        end else if (RegWrite && MemtoReg) begin
          // Gated by reset so a held lw does not show a stall while in reset.
          stall     = reset;
          ld_req_d  = 1'b1;
          ld_addr_d = ALU_Result;
          dest_d    = dest_now;
          cnt_d     = '0;
          state_d   = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // An ack on the final cycle still wins over the timeout.
        if (mem.ld_ack) begin
          we       = 1'b1;
          waddr    = dest_q;
          wdata    = mem.ld_data;
          ld_req_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          ld_req_d = 1'b0;
          ld_err_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // The load retires here; MemtoReg is still high but must not re-issue.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and load-channel registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dest_q    <= REG_ZERO;
      ld_req_q  <= 1'b0;
      ld_addr_q <= 32'h0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      ld_req_q  <= ld_req_d;
      ld_addr_q <= ld_addr_d;
      ld_err_q  <= ld_err_d;
    end
  end

  regfile32 #(.SP_INIT(SP_INIT)) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .raddr1_i (Instruction[25:21]),
    .raddr2_i (Instruction[20:16]),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .rdata1_o (Read_data_1),
    .rdata2_o (Read_data_2)
  );

  assign mem.ld_req  = ld_req_q;
  assign mem.ld_addr = ld_addr_q;
  assign ld_err      = ld_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_decode32_wb.sv
// Directed bench for decode32_wb: reset, ALU/jal write-back, immediate
// extension, load with ack, load timeout, ack-on-timeout and reset mid-load.
module tb_decode32_wb;
  import cpu_defs::*;

  logic        clock;
  logic        reset;
  logic [31:0] Instruction, PC_plus_4, ALU_Result;
  logic        RegWrite, RegDst, MemtoReg, Jal;
  logic [31:0] Read_data_1, Read_data_2, Sign_extend;
  logic        stall, ld_err;
  wb_state_t   dbg_state;
  int          n_checks;
  int          n_fail;
  int          req_rises;
  logic        req_prev;

  decode32_wb_if mem_if ();

  decode32_wb #(.LD_TIMEOUT(16), .SP_INIT(32'h0000_7FFC)) dut (
    .clock       (clock),
    .reset       (reset),
    .Instruction (Instruction),
    .PC_plus_4   (PC_plus_4),
    .ALU_Result  (ALU_Result),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .Jal         (Jal),
    .mem         (mem_if.master),
    .Read_data_1 (Read_data_1),
    .Read_data_2 (Read_data_2),
    .Sign_extend (Sign_extend),
    .stall       (stall),
    .ld_err      (ld_err),
    .dbg_state   (dbg_state)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count load requests issued (rising edges of ld_req).
  always @(posedge clock) begin
    if (mem_if.ld_req && !req_prev) req_rises++;
    req_prev <= mem_if.ld_req;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic idle_inputs();
    RegWrite = 1'b0; RegDst = 1'b0; MemtoReg = 1'b0; Jal = 1'b0;
    mem_if.ld_ack = 1'b0; mem_if.ld_data = 32'h0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; req_rises = 0; req_prev = 1'b0;
    reset = 1'b0;
    Instruction = 32'h0; PC_plus_4 = 32'h0; ALU_Result = 32'h0;
    idle_inputs();

    // Reset held for two edges.
    tick(); tick();
    Instruction = r_type(5'd29, 5'd5, 5'd0);
    #1;
    chk("rst_sp", Read_data_1, 32'h0000_7FFC);
    chk("rst_r5", Read_data_2, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(mem_if.ld_req), 32'h0);
    chk("rst_err", 32'(ld_err), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    tick();

    // ALU write to $8; not visible before the edge.
    Instruction = r_type(5'd8, 5'd0, 5'd8); ALU_Result = 32'h1234_5678;
    RegWrite = 1'b1; RegDst = 1'b1;
    #1;
    chk("alu_pre_edge", Read_data_1, 32'h0);
    chk("alu_stall", 32'(stall), 32'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    chk("alu_write", Read_data_1, 32'h1234_5678);

    // Write to $0 discarded.
    Instruction = r_type(5'd0, 5'd8, 5'd0); ALU_Result = 32'hDEAD_BEEF; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    #1;
    chk("zero_reg", Read_data_1, 32'h0);
    chk("r8_kept", Read_data_2, 32'h1234_5678);

    // jal writes PC+4 to $31 regardless of RegDst.
    Instruction = {OP_JAL, 26'h0}; PC_plus_4 = 32'h0040_0010; ALU_Result = 32'h1111_1111;
    Jal = 1'b1; RegWrite = 1'b1; RegDst = 1'b1;
    tick();
    idle_inputs();
    Instruction = r_type(5'd31, 5'd0, 5'd0);
    #1;
    chk("jal_ra", Read_data_1, 32'h0040_0010);

    // Immediate extension.
    Instruction = i_type(6'b001000, 5'd0, 5'd0, 16'h8001); #1;
    chk("ext_addi", Sign_extend, 32'hFFFF_8001);
    Instruction = i_type(OP_ORI, 5'd0, 5'd0, 16'h8001); #1;
    chk("ext_ori", Sign_extend, 32'h0000_8001);
    Instruction = i_type(OP_ANDI, 5'd0, 5'd0, 16'hF00F); #1;
    chk("ext_andi", Sign_extend, 32'h0000_F00F);
    Instruction = i_type(OP_XORI, 5'd0, 5'd0, 16'h8000); #1;
    chk("ext_xori", Sign_extend, 32'h0000_8000);
    Instruction = i_type(OP_SLTIU, 5'd0, 5'd0, 16'hFFFF); #1;
    chk("ext_sltiu", Sign_extend, 32'h0000_FFFF);
    Instruction = i_type(OP_LW, 5'd0, 5'd0, 16'hFFFC); #1;
    chk("ext_lw", Sign_extend, 32'hFFFF_FFFC);
    Instruction = i_type(6'b001000, 5'd0, 5'd0, 16'h7FFF); #1;
    chk("ext_pos", Sign_extend, 32'h0000_7FFF);

    // ld_ack in IDLE is ignored.
    Instruction = r_type(5'd0, 5'd9, 5'd0);
    mem_if.ld_ack = 1'b1; mem_if.ld_data = 32'h9999_9999;
    tick();
    idle_inputs();
    #1;
    chk("idle_ack_state", 32'(dbg_state), 32'(IDLE));
    chk("idle_ack_r9", Read_data_2, 32'h0);

    // Load with ack after three wait cycles.
    Instruction = i_type(OP_LW, 5'd0, 5'd9, 16'h0100); ALU_Result = 32'h0000_0100;
    RegWrite = 1'b1; MemtoReg = 1'b1;
    #1;
    chk("ld_stall_now", 32'(stall), 32'h1);
    chk("ld_req_not_yet", 32'(mem_if.ld_req), 32'h0);
    tick();
    chk("ld_req", 32'(mem_if.ld_req), 32'h1);
    chk("ld_addr", mem_if.ld_addr, 32'h0000_0100);
    chk("ld_wait_state", 32'(dbg_state), 32'(LOAD_WAIT));
    tick(); tick();
    chk("ld_wait_stall", 32'(stall), 32'h1);
    tick();
    mem_if.ld_ack = 1'b1; mem_if.ld_data = 32'hCAFE_BABE;
    tick();
    mem_if.ld_ack = 1'b0;
    #1;
    chk("ld_done_state", 32'(dbg_state), 32'(DONE));
    chk("ld_done_stall", 32'(stall), 32'h0);
    chk("ld_done_req", 32'(mem_if.ld_req), 32'h0);
    chk("ld_data_r9", Read_data_2, 32'hCAFE_BABE);
    tick();
    chk("ld_back_idle", 32'(dbg_state), 32'(IDLE));
    chk("ld_no_reissue", 32'(mem_if.ld_req), 32'h0);
    idle_inputs();
    chk("ld_one_req", 32'(req_rises), 32'd1);

    // Preload $10, then a load to it that times out.
    Instruction = r_type(5'd0, 5'd0, 5'd10); ALU_Result = 32'h55AA_55AA;
    RegWrite = 1'b1; RegDst = 1'b1;
    tick();
    Instruction = i_type(OP_LW, 5'd0, 5'd10, 16'h0200); ALU_Result = 32'h0000_0200;
    RegDst = 1'b0; MemtoReg = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_req_last", 32'(mem_if.ld_req), 32'h1);
    chk("to_err_before", 32'(ld_err), 32'h0);
    tick();
    chk("to_req_drop", 32'(mem_if.ld_req), 32'h0);
    chk("to_err_set", 32'(ld_err), 32'h1);
    chk("to_done", 32'(dbg_state), 32'(DONE));
    chk("to_r10_kept", Read_data_2, 32'h55AA_55AA);
    tick();
    idle_inputs();
    chk("to_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("to_err_sticky", 32'(ld_err), 32'h1);

    // Ack arriving on the timeout cycle still writes.
    Instruction = i_type(OP_LW, 5'd0, 5'd11, 16'h0300); ALU_Result = 32'h0000_0300;
    RegWrite = 1'b1; MemtoReg = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    mem_if.ld_ack = 1'b1; mem_if.ld_data = 32'h0BAD_F00D;
    tick();
    mem_if.ld_ack = 1'b0;
    #1;
    chk("ackto_r11", Read_data_2, 32'h0BAD_F00D);
    chk("ackto_done", 32'(dbg_state), 32'(DONE));
    chk("ackto_err", 32'(ld_err), 32'h1);
    tick();
    idle_inputs();

    // Reset during the second LOAD_WAIT cycle.
    Instruction = i_type(OP_LW, 5'd0, 5'd12, 16'h0400); ALU_Result = 32'h0000_0400;
    RegWrite = 1'b1; MemtoReg = 1'b1;
    tick();
    tick();
    chk("mid_wait", 32'(dbg_state), 32'(LOAD_WAIT));
    reset = 1'b0;
    mem_if.ld_ack = 1'b1; mem_if.ld_data = 32'h7777_7777;
    tick();
    #1;
    chk("mid_req", 32'(mem_if.ld_req), 32'h0);
    chk("mid_stall", 32'(stall), 32'h0);
    chk("mid_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_r12", Read_data_2, 32'h0);
    chk("mid_err_clr", 32'(ld_err), 32'h0);
    idle_inputs();
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
